cache_port_arbiter: RTL and testbench

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

---
 rtl/cache_arb_pkg.sv | 33 +++
 rtl/arb_rr2.sv | 36 +++
 rtl/cache_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : cache_arb_pkg
//  Description : Shared types and defaults for the cache port arbiter:
//                FSM state encoding, port-owner encoding, request bit
//                positions and default widths/timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

    // Bit positions inside the two-entry request / grant vectors.
    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage : cache_arb_pkg
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : arb_rr2
//  Description : Two-requester round-robin choice. A lone request is granted
//                directly; on a conflict the requester not granted last wins.
//                Grant is one-hot (bit REQ_I = instruction, REQ_D = data).
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    output logic [1:0] gnt_o
);

    // Combinational one-hot grant with alternation on conflict.
    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o[REQ_I] = 1'b1;
            2'b10:   gnt_o[REQ_D] = 1'b1;
            2'b11: begin
                if (last_i == OWN_I) begin
                    gnt_o[REQ_D] = 1'b1;
                end else begin
                    gnt_o[REQ_I] = 1'b1;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule : arb_rr2
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : cache_port_arbiter
//  Description : Shares one cache port between an instruction-fetch read port
//                and a data read/write port. Each access walks
//                IDLE -> ISSUE -> WAIT -> DONE; a hit completes 3 cycles after
//                the request is sampled, each stall cycle adds one. A stall
//                lasting TIMEOUT WAIT cycles ends the access with data 0 and
//                sets the sticky Err flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch read port
    input  logic              I_Req,
    input  logic [ADDR_W-1:0] I_Address,
    output logic              I_Ready,
    output logic [DATA_W-1:0] I_Data,
    // data port
    input  logic              D_Read,
    input  logic              D_Write,
    input  logic [ADDR_W-1:0] D_Address,
    input  logic [DATA_W-1:0] D_Data_In,
    output logic              D_Ready,
    output logic [DATA_W-1:0] D_Data_Out,
    // cache port
    output logic              Mem_Read,
    output logic              Mem_Write,
    output logic [ADDR_W-1:0] Word_address,
    output logic [DATA_W-1:0] Data_In,
    input  logic              stall,
    input  logic [DATA_W-1:0] Data_Out,
    // sticky timeout flag
    output logic              Err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q,  last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              err_q,   err_d;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;

    assign w_req[REQ_I] = I_Req;
    assign w_req[REQ_D] = D_Read | D_Write;

    arb_rr2 u_arb (
        .req_i  (w_req),
        .last_i (last_q),
        .gnt_o  (w_gnt)
    );

    // State and access-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;       // data wins the first conflict after reset
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: grant in IDLE, one-cycle issue, stall wait, one-cycle done.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (w_gnt[REQ_D]) begin
                    owner_d = OWN_D;
                    last_d  = OWN_D;
                    addr_d  = D_Address;
                    wdata_d = D_Data_In;
                    write_d = D_Write;      // read+write together counts as write
                    state_d = ST_ISSUE;
                end else if (w_gnt[REQ_I]) begin
                    owner_d = OWN_I;
                    last_d  = OWN_I;
                    addr_d  = I_Address;
                    wdata_d = '0;
                    write_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!stall) begin
                    rdata_d = write_q ? wdata_q : Data_Out;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: everything is zero outside the state that drives it.
    always_comb begin
        Mem_Read     = 1'b0;
        Mem_Write    = 1'b0;
        Word_address = '0;
        Data_In      = '0;
        I_Ready      = 1'b0;
        I_Data       = '0;
        D_Ready      = 1'b0;
        D_Data_Out   = '0;
        if (state_q == ST_ISSUE) begin
            Mem_Read     = ~write_q;
            Mem_Write    = write_q;
            Word_address = addr_q;
            Data_In      = write_q ? wdata_q : '0;
        end
        if (state_q == ST_DONE) begin
            if (owner_q == OWN_D) begin
                D_Ready    = 1'b1;
                D_Data_Out = rdata_q;
            end else begin
                I_Ready    = 1'b1;
                I_Data     = rdata_q;
            end
        end
    end

    assign Err = err_q;

endmodule : cache_port_arbiter
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cache_port_arbiter
//  Description : Directed self-checking bench for cache_port_arbiter with
//                hand-computed latencies and data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_Req;
    logic [9:0]  I_Address;
    logic        I_Ready;
    logic [31:0] I_Data;
    logic        D_Read;
    logic        D_Write;
    logic [9:0]  D_Address;
    logic [31:0] D_Data_In;
    logic        D_Ready;
    logic [31:0] D_Data_Out;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [9:0]  Word_address;
    logic [31:0] Data_In;
    logic        stall;
    logic [31:0] Data_Out;
    logic        Err;

    int n_checks = 0;
    int n_fail   = 0;

    cache_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .I_Req        (I_Req),
        .I_Address    (I_Address),
        .I_Ready      (I_Ready),
        .I_Data       (I_Data),
        .D_Read       (D_Read),
        .D_Write      (D_Write),
        .D_Address    (D_Address),
        .D_Data_In    (D_Data_In),
        .D_Ready      (D_Ready),
        .D_Data_Out   (D_Data_Out),
        .Mem_Read     (Mem_Read),
        .Mem_Write    (Mem_Write),
        .Word_address (Word_address),
        .Data_In      (Data_In),
        .stall        (stall),
        .Data_Out     (Data_Out),
        .Err          (Err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Protocol watch on every falling edge outside reset.
    logic prev_rd = 1'b0, prev_wr = 1'b0, prev_ir = 1'b0, prev_dr = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("rw_excl",  32'(Mem_Read & Mem_Write), 32'd0);
            check("rdy_excl", 32'(I_Ready & D_Ready), 32'd0);
            check("rd_pulse", 32'(prev_rd & Mem_Read), 32'd0);
            check("wr_pulse", 32'(prev_wr & Mem_Write), 32'd0);
            check("ir_pulse", 32'(prev_ir & I_Ready), 32'd0);
            check("dr_pulse", 32'(prev_dr & D_Ready), 32'd0);
        end
        prev_rd = Mem_Read;
        prev_wr = Mem_Write;
        prev_ir = I_Ready;
        prev_dr = D_Ready;
    end

    // Results of the most recent wait_ready call.
    int          r_cyc;
    logic        r_gi, r_gd;
    logic [31:0] r_data;
    int          m_cyc;
    logic        m_rd, m_wr;
    logic [9:0]  m_addr;
    logic [31:0] m_data;

    // Called at a falling edge right after driving a request. Counts falling
    // edges until a Ready pulse; keeps stall high for the first s_cyc WAIT
    // cycles (stall at edge k is sampled by the rising edge k).
    task automatic wait_ready(input int s_cyc, input int budget);
        r_cyc = 0; r_gi = 0; r_gd = 0; r_data = '0;
        m_cyc = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_data = '0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            stall = (k <= s_cyc + 1);
            if (Mem_Read | Mem_Write) begin
                m_cyc = k; m_rd = Mem_Read; m_wr = Mem_Write;
                m_addr = Word_address; m_data = Data_In;
            end
            if (I_Ready | D_Ready) begin
                r_cyc = k; r_gi = I_Ready; r_gd = D_Ready;
                r_data = I_Ready ? I_Data : D_Data_Out;
                break;
            end
        end
        check("ready_seen", 32'(r_cyc != 0), 32'd1);
        stall = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mrd"},  32'(Mem_Read), 32'd0);
        check({tag, "_mwr"},  32'(Mem_Write), 32'd0);
        check({tag, "_addr"}, 32'(Word_address), 32'd0);
        check({tag, "_din"},  Data_In, 32'd0);
        check({tag, "_irdy"}, 32'(I_Ready), 32'd0);
        check({tag, "_idat"}, I_Data, 32'd0);
        check({tag, "_drdy"}, 32'(D_Ready), 32'd0);
        check({tag, "_ddat"}, D_Data_Out, 32'd0);
    endtask

    initial begin
        rst = 1'b1; I_Req = 0; I_Address = '0; D_Read = 0; D_Write = 0;
        D_Address = '0; D_Data_In = '0; stall = 0; Data_Out = '0;
        @(negedge clk);
        do_reset();
        check_idle_outputs("rst");
        check("rst_err", 32'(Err), 32'd0);

        // Single data write, hit.
        D_Write = 1; D_Address = 10'b111_00010_01; D_Data_In = 32'd16; Data_Out = 32'd99;
        wait_ready(0, 20);
        D_Write = 0;
        check("wr_lat",   32'(r_cyc), 32'd3);
        check("wr_dport", 32'(r_gd), 32'd1);
        check("wr_data",  r_data, 32'd16);
        check("wr_mcyc",  32'(m_cyc), 32'd1);
        check("wr_mwr",   32'(m_wr), 32'd1);
        check("wr_maddr", 32'(m_addr), 32'h389);
        check("wr_mdin",  m_data, 32'd16);

        // Fetch miss with 4 stall cycles.
        @(negedge clk);
        I_Req = 1; I_Address = 10'b111_00010_11; Data_Out = 32'd2;
        wait_ready(4, 30);
        I_Req = 0;
        check("fm_lat",   32'(r_cyc), 32'd7);
        check("fm_iport", 32'(r_gi), 32'd1);
        check("fm_data",  r_data, 32'd2);
        check("fm_mrd",   32'(m_rd), 32'd1);
        check("fm_maddr", 32'(m_addr), 32'h38B);

        // Conflicts after reset alternate D, I, D, I.
        @(negedge clk);
        do_reset();
        I_Req = 1; D_Read = 1; I_Address = 10'd7; D_Address = 10'd9; Data_Out = 32'd5;
        for (int n = 0; n < 4; n++) begin
            wait_ready(0, 20);
            check("cf_lat", 32'(r_cyc), (n == 0) ? 32'd3 : 32'd4);
            check("cf_dgnt", 32'(r_gd), (n % 2 == 0) ? 32'd1 : 32'd0);
            check("cf_maddr", 32'(m_addr), (n % 2 == 0) ? 32'd9 : 32'd7);
        end
        I_Req = 0; D_Read = 0;

        // Timeout on a stuck stall.
        @(negedge clk);
        D_Read = 1; D_Address = 10'd3; Data_Out = 32'd77;
        wait_ready(1000, 100);
        D_Read = 0;
        check("to_lat",   32'(r_cyc), 32'd66);
        check("to_dport", 32'(r_gd), 32'd1);
        check("to_data",  r_data, 32'd0);
        check("to_err",   32'(Err), 32'd1);
        repeat (3) @(negedge clk);
        check("to_err_sticky", 32'(Err), 32'd1);

        // Reset in the middle of a miss, then a normal hit read.
        D_Read = 1; D_Address = 10'd12; stall = 1;
        repeat (4) @(negedge clk);
        rst = 1; D_Read = 0;
        @(negedge clk);
        check_idle_outputs("mid");
        check("mid_err", 32'(Err), 32'd0);
        rst = 0; stall = 0;
        repeat (3) begin
            @(negedge clk);
            check("mid_no_rdy", 32'(I_Ready | D_Ready), 32'd0);
        end
        D_Read = 1; D_Address = 10'b101_00010_10; Data_Out = 32'd220;
        wait_ready(0, 20);
        D_Read = 0;
        check("hit_lat",   32'(r_cyc), 32'd3);
        check("hit_dport", 32'(r_gd), 32'd1);
        check("hit_data",  r_data, 32'd220);
        check("hit_maddr", 32'(m_addr), 32'h28A);
        check("hit_err",   32'(Err), 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cache_port_arbiter
`default_nettype wire
